// File: rtl/mp64_clkgate_ctrl.sv
// mp64_clkgate_ctrl: idle-qualified clock gate controller with wake settle and gated-cycle statistics
module mp64_clkgate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        busy,
  input  logic        sleep_req,
  input  logic        wake_req,
  input  logic        force_on,
  input  logic        clr_stats,
  output logic        gate_en,
  output logic        sleep_ack,
  output logic        awake,
  output logic [1:0]  state,
  output logic [31:0] gated_cycles
);
  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] GATED = 2'd2;
  localparam logic [1:0] WAKE  = 2'd3;
  localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
  localparam logic [7:0] WAKE_LAST = 8'(WAKE_CYCLES - 1);
  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] gated_cycles_q, gated_cycles_d;
  logic        abort;
  // Any reason to keep or bring back the clock; also the exact complement of the sleep entry condition
  assign abort = busy | ~sleep_req | force_on | wake_req;
  // Next-state: idle qualification in COUNT, unconditional settle countdown in WAKE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: if (!abort) begin
        state_d = COUNT;
        cnt_d   = '0;
      end
      COUNT: if (abort) begin
        state_d = RUN;
        cnt_d   = '0;
      end else if (cnt_q == IDLE_LAST) state_d = GATED;
      else cnt_d = cnt_q + 8'd1;
      GATED: if (abort) begin
        state_d = WAKE;
        cnt_d   = '0;
      end
      default: if (cnt_q == WAKE_LAST) begin
        state_d = RUN;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 8'd1;
    endcase
  end
  // Saturating residency counter; clear wins over increment
  always_comb begin
    gated_cycles_d = clr_stats ? '0 :
                     (state_q == GATED && !(&gated_cycles_q)) ? gated_cycles_q + 32'd1 :
                     gated_cycles_q;
  end
  // State registers; reset forces RUN so the clock is re-enabled without a settle phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      gated_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      gated_cycles_q <= gated_cycles_d;
    end
  end
  assign gate_en      = state_q != GATED;
  assign sleep_ack    = state_q == GATED;
  assign awake        = ~state_q[1];
  assign state        = state_q;
  assign gated_cycles = gated_cycles_q;
endmodule

// File: tb/tb_mp64_clkgate_ctrl.sv
// tb_mp64_clkgate_ctrl: directed scenarios plus randomized run against a behavioural model
module tb_mp64_clkgate_ctrl;
  localparam int IC = 4;
  localparam int WC = 2;
  logic clk = 1'b0;
  logic rst, busy, sleep_req, wake_req, force_on, clr_stats;
  logic ge0, sa0, aw0, ge1, sa1, aw1;
  logic [1:0] st0, st1;
  logic [31:0] gc0, gc1;
  int errors = 0;
  int checks = 0;
  int m_idle[2];
  int m_wake[2];
  bit m_gated[2];
  longint m_gc[2];

  mp64_clkgate_ctrl #(.IDLE_CYCLES(IC), .WAKE_CYCLES(WC)) dut0 (
    .clk(clk), .rst(rst), .busy(busy), .sleep_req(sleep_req), .wake_req(wake_req),
    .force_on(force_on), .clr_stats(clr_stats), .gate_en(ge0), .sleep_ack(sa0),
    .awake(aw0), .state(st0), .gated_cycles(gc0));

  mp64_clkgate_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .busy(busy), .sleep_req(sleep_req), .wake_req(wake_req),
    .force_on(force_on), .clr_stats(clr_stats), .gate_en(ge1), .sleep_ack(sa1),
    .awake(aw1), .state(st1), .gated_cycles(gc1));

  always #5 clk = ~clk;

  function automatic int p_idle(int i);
    return i == 0 ? IC : 1;
  endfunction

  function automatic int p_wake(int i);
    return i == 0 ? WC : 1;
  endfunction

  function automatic logic [1:0] m_state(int i);
    return m_wake[i] > 0 ? 2'd3 : m_gated[i] ? 2'd2 : m_idle[i] > 0 ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [36:0] m_vec(int i);
    return {~m_gated[i], m_gated[i], ~m_gated[i] && m_wake[i] == 0, m_state(i), m_gc[i][31:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_idle[i] = 0;
      m_wake[i] = 0;
      m_gated[i] = 0;
      m_gc[i] = 0;
    end
  endtask

  // m_idle counts consecutive qualifying edges; the domain gates once it exceeds the idle budget
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit was_gated = m_gated[i];
      if (m_wake[i] > 0) m_wake[i]--;
      else if (m_gated[i]) begin
        if (wake_req || force_on || !sleep_req || busy) begin
          m_gated[i] = 0;
          m_wake[i] = p_wake(i);
        end
      end else if (sleep_req && !busy && !force_on && !wake_req) begin
        m_idle[i]++;
        if (m_idle[i] > p_idle(i)) begin
          m_gated[i] = 1;
          m_idle[i] = 0;
        end
      end else m_idle[i] = 0;
      if (clr_stats) m_gc[i] = 0;
      else if (was_gated && m_gc[i] < 64'hFFFF_FFFF) m_gc[i]++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic settle_run();
    sleep_req = 0; busy = 0; wake_req = 0; force_on = 0; clr_stats = 0;
    for (int k = 0; k < 8; k++) tick();
  endtask

  task automatic test_reset();
    rst = 1; busy = 0; sleep_req = 0; wake_req = 0; force_on = 0; clr_stats = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ge0, sa0, aw0, st0, gc0} !== {1'b1, 1'b0, 1'b1, 2'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=%h", {ge0, sa0, aw0, st0, gc0}, {1'b1, 1'b0, 1'b1, 2'd0, 32'd0});
    end
    rst = 0;
  endtask

  task automatic test_nominal_sleep();
    sleep_req = 1; busy = 0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (ge0 !== (e <= 4) || sa0 !== (e >= 5) || st0 !== (e <= 4 ? 2'd1 : 2'd2)) begin
        errors++;
        $display("FAIL nominal_sleep e=%0d got ge=%b sa=%b st=%0d", e, ge0, sa0, st0);
      end
      if (e <= 2) begin
        checks++;
        if (st1 !== 2'(e)) begin
          errors++;
          $display("FAIL idle1_boundary e=%0d got st=%0d exp=%0d", e, st1, e);
        end
      end
    end
    checks++;
    if (gc0 !== 32'd3) begin
      errors++;
      $display("FAIL nominal_stats got=%0d exp=3", gc0);
    end
  endtask

  task automatic test_wake();
    logic [1:0] exp_st [3] = '{2'd3, 2'd3, 2'd0};
    logic [1:0] exp_st1 [3] = '{2'd3, 2'd0, 2'd1};
    wake_req = 1;
    for (int e = 0; e < 3; e++) begin
      tick();
      wake_req = 0;
      checks++;
      if (st0 !== exp_st[e] || ge0 !== 1'b1 || aw0 !== (e == 2)) begin
        errors++;
        $display("FAIL wake e=%0d got st=%0d ge=%b aw=%b exp st=%0d", e, st0, ge0, aw0, exp_st[e]);
      end
      checks++;
      if (st1 !== exp_st1[e]) begin
        errors++;
        $display("FAIL wake1_boundary e=%0d got st=%0d exp=%0d", e, st1, exp_st1[e]);
      end
    end
  endtask

  task automatic test_idle_abort();
    settle_run();
    sleep_req = 1;
    tick();
    busy = 1;
    tick();
    busy = 0;
    checks++;
    if (st0 !== 2'd0) begin
      errors++;
      $display("FAIL abort_to_run got st=%0d exp=0", st0);
    end
    for (int e = 1; e <= 5; e++) begin
      tick();
      checks++;
      if (ge0 !== (e < 5) || st0 !== (e < 5 ? 2'd1 : 2'd2)) begin
        errors++;
        $display("FAIL abort_regate e=%0d got ge=%b st=%0d", e, ge0, st0);
      end
    end
  endtask

  task automatic test_priority();
    settle_run();
    for (int f = 0; f < 2; f++) begin
      sleep_req = 1; wake_req = (f == 0); force_on = (f == 1);
      for (int k = 0; k < 20; k++) begin
        tick();
        checks++;
        if (st0 !== 2'd0 || ge0 !== 1'b1 || st1 !== 2'd0 || ge1 !== 1'b1) begin
          errors++;
          $display("FAIL priority f=%0d k=%0d got st0=%0d ge0=%b st1=%0d ge1=%b", f, k, st0, ge0, st1, ge1);
        end
      end
    end
    settle_run();
  endtask

  task automatic test_async_reset();
    sleep_req = 1; clr_stats = 1;
    repeat (5) tick();
    clr_stats = 0;
    repeat (10) tick();
    checks++;
    if (st0 !== 2'd2 || gc0 !== 32'd10) begin
      errors++;
      $display("FAIL pre_reset got st=%0d gc=%0d exp st=2 gc=10", st0, gc0);
    end
    #2 rst = 1;
    model_reset();
    #1;
    checks++;
    if ({ge0, sa0, aw0, st0, gc0} !== {1'b1, 1'b0, 1'b1, 2'd0, 32'd0}) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", {ge0, sa0, aw0, st0, gc0}, {1'b1, 1'b0, 1'b1, 2'd0, 32'd0});
    end
    @(negedge clk);
    rst = 0;
    tick();
    checks++;
    if (st0 !== 2'd1) begin
      errors++;
      $display("FAIL post_reset got st=%0d exp=1", st0);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] exp_gc [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2};
    sleep_req = 1;
    for (int k = 0; k < 10 && !m_gated[0]; k++) tick();
    force dut0.gated_cycles_q = 32'hFFFF_FFFE;
    #1 release dut0.gated_cycles_q;
    m_gc[0] = 64'hFFFF_FFFE;
    for (int e = 0; e < 5; e++) begin
      clr_stats = (e == 2);
      tick();
      checks++;
      if (gc0 !== exp_gc[e] || st0 !== 2'd2) begin
        errors++;
        $display("FAIL saturation e=%0d got gc=%h st=%0d exp gc=%h", e, gc0, st0, exp_gc[e]);
      end
    end
    clr_stats = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      sleep_req = ($urandom % 8) != 0;
      busy = ($urandom % 16) == 0;
      wake_req = ($urandom % 32) == 0;
      force_on = ($urandom % 64) == 0;
      clr_stats = ($urandom % 128) == 0;
      tick();
      checks++;
      if ({ge0, sa0, aw0, st0, gc0} !== m_vec(0) || {ge1, sa1, aw1, st1, gc1} !== m_vec(1)) begin
        errors++;
        $display("FAIL random k=%0d got0=%h exp0=%h got1=%h exp1=%h", k,
                 {ge0, sa0, aw0, st0, gc0}, m_vec(0), {ge1, sa1, aw1, st1, gc1}, m_vec(1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal_sleep();
    test_wake();
    test_idle_abort();
    test_priority();
    test_async_reset();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
